// File: rtl/rf_pkg.sv
// Shared register-file types for the writeback scheduler.
// Provides XLEN, the architectural register count and the index/data types.
package rf_pkg;

  localparam int XLEN          = 32;
  localparam int NUM_ARCH_REGS = 32;

  typedef logic [4:0]      reg_idx_t;
  typedef logic [XLEN-1:0] xdata_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr, ascending, wraps.
// Ports: req[N] in, ptr in, gnt[N] one-hot or zero out, gnt_idx out.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  int   idx;
  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Shares the reg-file write port between writeback units and keeps the
// pending-write scoreboard that stalls issue on RAW/WAW hazards.
// Ports: wb_* requester side, iss_* issue side, rd_* registered write port,
// pending scoreboard, sb_err sticky commit-without-pending error.
module rf_wb_scheduler
  import rf_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int XLEN    = rf_pkg::XLEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SRC-1:0]      wb_valid,
  output logic [NUM_SRC-1:0]      wb_ready,
  input  logic [NUM_SRC*5-1:0]    wb_rd_addr,
  input  logic [NUM_SRC*XLEN-1:0] wb_rd_data,
  input  logic                    iss_valid,
  input  logic                    iss_rd_we,
  input  logic [4:0]              iss_rd_addr,
  input  logic                    iss_rs1_used,
  input  logic [4:0]              iss_rs1_addr,
  input  logic                    iss_rs2_used,
  input  logic [4:0]              iss_rs2_addr,
  output logic                    iss_stall,
  output logic                    rd_wr_en,
  output logic [4:0]              rd_addr,
  output logic [XLEN-1:0]         rd_data,
  output logic [31:0]             pending,
  output logic                    sb_err
);

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      gnt_idx;
  logic [PW-1:0]      ptr_nxt;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] gnt;
  logic               hs;
  reg_idx_t           sel_addr;
  logic [XLEN-1:0]    sel_data;
  logic               sb_set;
  logic               sb_clr;
  logic [31:0]        pend_nxt;

  // No grants while in reset so nothing is consumed and dropped.
  assign req = wb_valid & {NUM_SRC{~rst}};

  rr_arbiter #(
    .N  (NUM_SRC),
    .PW (PW)
  ) u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign wb_ready = gnt;
  assign hs       = |gnt;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt[i]) begin
        sel_addr = wb_rd_addr[i*5 +: 5];
        sel_data = wb_rd_data[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    ptr_nxt = gnt_idx + PW'(1);
    if (gnt_idx == PW'(NUM_SRC - 1)) ptr_nxt = '0;
  end

  // pending[0] is held at 0, so x0 never stalls.
  assign iss_stall = iss_valid &
    ((iss_rs1_used & pending[iss_rs1_addr]) |
     (iss_rs2_used & pending[iss_rs2_addr]) |
     (iss_rd_we    & pending[iss_rd_addr]));

  assign sb_set = iss_valid & ~iss_stall & iss_rd_we &
                  (iss_rd_addr != 5'd0);
  assign sb_clr = rd_wr_en & (rd_addr != 5'd0);

  always_comb begin
    pend_nxt = pending;
    if (sb_clr) pend_nxt[rd_addr] = 1'b0;
    if (sb_set) pend_nxt[iss_rd_addr] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_wr_en <= 1'b0;
      rd_addr  <= '0;
      rd_data  <= '0;
      pending  <= '0;
      rr_ptr   <= '0;
      sb_err   <= 1'b0;
    end else begin
      rd_wr_en <= hs & (sel_addr != 5'd0);
      if (hs) begin
        rd_addr <= sel_addr;
        rd_data <= sel_data;
        rr_ptr  <= ptr_nxt;
      end
      pending <= pend_nxt;
      if (sb_clr && !pending[rd_addr]) sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed self-checking bench for rf_wb_scheduler.
// One task per scenario, inline comparisons, single summary line.
module tb_rf_wb_scheduler;

  localparam int NS = 3;
  localparam int XL = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [NS-1:0]  wb_valid;
  logic [NS-1:0]  wb_ready;
  logic [NS*5-1:0]  wb_rd_addr;
  logic [NS*XL-1:0] wb_rd_data;
  logic        iss_valid;
  logic        iss_rd_we;
  logic [4:0]  iss_rd_addr;
  logic        iss_rs1_used;
  logic [4:0]  iss_rs1_addr;
  logic        iss_rs2_used;
  logic [4:0]  iss_rs2_addr;
  logic        iss_stall;
  logic        rd_wr_en;
  logic [4:0]  rd_addr;
  logic [XL-1:0] rd_data;
  logic [31:0] pending;
  logic        sb_err;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rf_wb_scheduler #(
    .NUM_SRC (NS),
    .XLEN    (XL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_rd_addr   (wb_rd_addr),
    .wb_rd_data   (wb_rd_data),
    .iss_valid    (iss_valid),
    .iss_rd_we    (iss_rd_we),
    .iss_rd_addr  (iss_rd_addr),
    .iss_rs1_used (iss_rs1_used),
    .iss_rs1_addr (iss_rs1_addr),
    .iss_rs2_used (iss_rs2_used),
    .iss_rs2_addr (iss_rs2_addr),
    .iss_stall    (iss_stall),
    .rd_wr_en     (rd_wr_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .pending      (pending),
    .sb_err       (sb_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic iss_idle();
    iss_valid    = 1'b0;
    iss_rd_we    = 1'b0;
    iss_rd_addr  = 5'd0;
    iss_rs1_used = 1'b0;
    iss_rs1_addr = 5'd0;
    iss_rs2_used = 1'b0;
    iss_rs2_addr = 5'd0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    wb_valid   = 3'b111;
    wb_rd_addr = '0;
    wb_rd_data = '0;
    iss_idle();
    for (int c = 0; c < 2; c++) begin
      tick();
      n_chk++;
      if (wb_ready !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_ready c=%0d got=%b exp=000", c, wb_ready);
      end
      n_chk++;
      if (rd_wr_en !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_wr_en got=%b exp=0", rd_wr_en);
      end
      n_chk++;
      if (pending !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_pending got=%h exp=0", pending);
      end
    end
    n_chk++;
    if (sb_err !== 1'b0 || rd_addr !== 5'd0 || rd_data !== '0) begin
      n_fail++;
      $display("FAIL reset_regs err=%b addr=%0d data=%h exp 0/0/0",
               sb_err, rd_addr, rd_data);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp;
    rst = 1'b0;
    wb_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      exp = 3'b001 << (c % 3);
      #1;
      n_chk++;
      if (wb_ready !== exp) begin
        n_fail++;
        $display("FAIL rr_grant c=%0d got=%b exp=%b", c, wb_ready, exp);
      end
      tick();
    end
    wb_valid = 3'b000;
    #1;
    n_chk++;
    if (rd_wr_en !== 1'b0 || sb_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_x0_writes wr_en=%b err=%b exp 0/0",
               rd_wr_en, sb_err);
    end
    tick();
  endtask

  task automatic test_commit();
    iss_valid   = 1'b1;
    iss_rd_we   = 1'b1;
    iss_rd_addr = 5'd5;
    #1;
    n_chk++;
    if (iss_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL commit_issue_stall got=%b exp=0", iss_stall);
    end
    tick();
    iss_idle();
    n_chk++;
    if (pending !== 32'h0000_0020) begin
      n_fail++;
      $display("FAIL commit_pend_set got=%h exp=00000020", pending);
    end
    wb_valid   = 3'b010;
    wb_rd_addr = {5'd0, 5'd5, 5'd0};
    wb_rd_data = {32'h0, 32'h0000_DEAD, 32'h0};
    #1;
    n_chk++;
    if (wb_ready !== 3'b010) begin
      n_fail++;
      $display("FAIL commit_ready got=%b exp=010", wb_ready);
    end
    tick();
    wb_valid = 3'b000;
    n_chk++;
    if (rd_wr_en !== 1'b1 || rd_addr !== 5'd5 ||
        rd_data !== 32'h0000_DEAD) begin
      n_fail++;
      $display("FAIL commit_port en=%b addr=%0d data=%h exp 1/5/0000dead",
               rd_wr_en, rd_addr, rd_data);
    end
    n_chk++;
    if (pending[5] !== 1'b1) begin
      n_fail++;
      $display("FAIL commit_pend_n1 got=%b exp=1", pending[5]);
    end
    tick();
    n_chk++;
    if (pending[5] !== 1'b0 || rd_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL commit_n2 pend=%b en=%b exp 0/0",
               pending[5], rd_wr_en);
    end
    n_chk++;
    if (rd_addr !== 5'd5 || rd_data !== 32'h0000_DEAD) begin
      n_fail++;
      $display("FAIL commit_hold addr=%0d data=%h exp 5/0000dead",
               rd_addr, rd_data);
    end
  endtask

  task automatic test_stall();
    iss_valid   = 1'b1;
    iss_rd_we   = 1'b1;
    iss_rd_addr = 5'd5;
    tick();
    iss_idle();
    iss_valid    = 1'b1;
    iss_rs1_used = 1'b1;
    iss_rs1_addr = 5'd5;
    #1;
    n_chk++;
    if (iss_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_raw got=%b exp=1", iss_stall);
    end
    iss_rs1_used = 1'b0;
    iss_rd_we    = 1'b1;
    iss_rd_addr  = 5'd5;
    #1;
    n_chk++;
    if (iss_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_waw got=%b exp=1", iss_stall);
    end
    iss_rd_we    = 1'b0;
    iss_rs2_used = 1'b1;
    iss_rs2_addr = 5'd6;
    #1;
    n_chk++;
    if (iss_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_free_rs2 got=%b exp=0", iss_stall);
    end
    iss_rs2_used = 1'b0;
    iss_rs1_used = 1'b1;
    tick();
    // rr_ptr is 2: only src0 requests, search 2 -> 0
    wb_valid   = 3'b001;
    wb_rd_addr = {5'd0, 5'd0, 5'd5};
    wb_rd_data = {32'h0, 32'h0, 32'h0000_1234};
    #1;
    n_chk++;
    if (wb_ready !== 3'b001 || iss_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_n ready=%b stall=%b exp 001/1",
               wb_ready, iss_stall);
    end
    tick();
    wb_valid = 3'b000;
    #1;
    n_chk++;
    if (iss_stall !== 1'b1 || rd_wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_n1 stall=%b en=%b exp 1/1", iss_stall, rd_wr_en);
    end
    tick();
    n_chk++;
    if (iss_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_n2 got=%b exp=0", iss_stall);
    end
    iss_idle();
  endtask

  task automatic test_x0();
    iss_valid    = 1'b1;
    iss_rs1_used = 1'b1;
    iss_rs1_addr = 5'd0;
    iss_rd_we    = 1'b1;
    iss_rd_addr  = 5'd0;
    #1;
    n_chk++;
    if (iss_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_issue_stall got=%b exp=0", iss_stall);
    end
    tick();
    iss_idle();
    n_chk++;
    if (pending !== 32'h0) begin
      n_fail++;
      $display("FAIL x0_pending got=%h exp=0", pending);
    end
    // rr_ptr is 1: search 1,2,0 -> src0
    wb_valid   = 3'b001;
    wb_rd_addr = {5'd0, 5'd0, 5'd0};
    wb_rd_data = {32'h0, 32'h0, 32'hCAFE_F00D};
    #1;
    n_chk++;
    if (wb_ready !== 3'b001) begin
      n_fail++;
      $display("FAIL x0_ready got=%b exp=001", wb_ready);
    end
    tick();
    wb_valid = 3'b000;
    n_chk++;
    if (rd_wr_en !== 1'b0 || sb_err !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_write en=%b err=%b exp 0/0", rd_wr_en, sb_err);
    end
    tick();
    n_chk++;
    if (sb_err !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_err got=%b exp=0", sb_err);
    end
  endtask

  task automatic test_sb_err();
    // rr_ptr is 1: only src2 requests
    wb_valid   = 3'b100;
    wb_rd_addr = {5'd7, 5'd0, 5'd0};
    wb_rd_data = {32'h0000_0077, 32'h0, 32'h0};
    #1;
    n_chk++;
    if (wb_ready !== 3'b100) begin
      n_fail++;
      $display("FAIL err_ready got=%b exp=100", wb_ready);
    end
    tick();
    wb_valid = 3'b000;
    n_chk++;
    if (rd_wr_en !== 1'b1 || rd_addr !== 5'd7 ||
        rd_data !== 32'h0000_0077 || sb_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_write en=%b addr=%0d data=%h err=%b exp 1/7/77/0",
               rd_wr_en, rd_addr, rd_data, sb_err);
    end
    tick();
    n_chk++;
    if (sb_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set got=%b exp=1", sb_err);
    end
    tick();
    tick();
    n_chk++;
    if (sb_err !== 1'b1 || pending !== 32'h0) begin
      n_fail++;
      $display("FAIL err_sticky err=%b pend=%h exp 1/0", sb_err, pending);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if (sb_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_rst got=%b exp=0", sb_err);
    end
  endtask

  task automatic test_back_to_back();
    // rr_ptr is 0 after reset: src1 then src2 on consecutive cycles
    iss_valid   = 1'b1;
    iss_rd_we   = 1'b1;
    iss_rd_addr = 5'd9;
    tick();
    iss_rd_addr = 5'd10;
    tick();
    iss_idle();
    n_chk++;
    if (pending !== 32'h0000_0600) begin
      n_fail++;
      $display("FAIL b2b_pend got=%h exp=00000600", pending);
    end
    wb_valid   = 3'b110;
    wb_rd_addr = {5'd10, 5'd9, 5'd0};
    wb_rd_data = {32'hAAAA_0010, 32'hBBBB_0009, 32'h0};
    tick();
    wb_valid = 3'b100;
    n_chk++;
    if (rd_addr !== 5'd9 || rd_data !== 32'hBBBB_0009 ||
        rd_wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first addr=%0d data=%h en=%b exp 9/bbbb0009/1",
               rd_addr, rd_data, rd_wr_en);
    end
    tick();
    wb_valid = 3'b000;
    n_chk++;
    if (rd_addr !== 5'd10 || rd_data !== 32'hAAAA_0010 ||
        pending !== 32'h0000_0400) begin
      n_fail++;
      $display("FAIL b2b_second addr=%0d data=%h pend=%h exp 10/aaaa0010/400",
               rd_addr, rd_data, pending);
    end
    tick();
    n_chk++;
    if (pending !== 32'h0 || sb_err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done pend=%h err=%b exp 0/0", pending, sb_err);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_commit();
    test_stall();
    test_x0();
    test_sb_err();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
